// File: rtl/tri_raster_ctrl_if.sv
// Vertex-in / pixel-out bus for tri_raster_ctrl.
// master = vertex source plus pixel sink; slave = the scan controller.
interface tri_raster_ctrl_if #(parameter int W = 12);
  logic           start;
  logic [W-1:0]   p1X, p1Y, p2X, p2Y, p3X, p3Y;
  logic           busy;
  logic [W-1:0]   pix_x, pix_y;
  logic           pix_in;
  logic           pix_valid;
  logic           pix_ready;
  logic           done;
  logic [2*W:0]   in_count;

  modport master (
    output start, p1X, p1Y, p2X, p2Y, p3X, p3Y, pix_ready,
    input  busy, pix_x, pix_y, pix_in, pix_valid, done, in_count
  );

  modport slave (
    input  start, p1X, p1Y, p2X, p2Y, p3X, p3Y, pix_ready,
    output busy, pix_x, pix_y, pix_in, pix_valid, done, in_count
  );
endinterface

// File: rtl/tri_raster_ctrl.sv
// Bounding-box scan of a triangle, one shared edge-sign evaluator stepped
// across the three edges per pixel, results streamed over valid/ready.
module tri_raster_ctrl #(
  parameter int W        = 12,
  parameter bit EMIT_ALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  tri_raster_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_BBOX, S_EVAL, S_EMIT, S_NEXT, S_DONE} state_e;

  state_e               state_q;
  logic [2:0][W-1:0]    vx_q, vy_q;
  logic [W-1:0]         xmin_q, xmax_q, ymin_q, ymax_q;
  logic [W-1:0]         x_q, y_q;
  logic [1:0]           k_q;
  logic                 inside_q, valid_q, busy_q, done_q;
  logic [2*W:0]         cnt_q;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Edge k uses vertex pair (k, k+1 mod 3).
  logic [W-1:0]         ax_d, ay_d, bx_d, by_d;
  always_comb begin
    ax_d = vx_q[0]; ay_d = vy_q[0]; bx_d = vx_q[1]; by_d = vy_q[1];
    unique case (k_q)
      2'd1:    begin ax_d = vx_q[1]; ay_d = vy_q[1]; bx_d = vx_q[2]; by_d = vy_q[2]; end
      2'd2:    begin ax_d = vx_q[2]; ay_d = vy_q[2]; bx_d = vx_q[0]; by_d = vy_q[0]; end
      default: ;
    endcase
  end

  // Differences of two W-bit unsigned values fit W+1 signed bits exactly.
  logic signed [W:0]     dtx, day, dax, dty;
  logic signed [2*W+1:0] prod0, prod1;
  logic signed [2*W+2:0] s_edge;
  logic                  edge_pass;

  assign dtx       = $signed({1'b0, x_q})  - $signed({1'b0, bx_d});
  assign day       = $signed({1'b0, ay_d}) - $signed({1'b0, by_d});
  assign dax       = $signed({1'b0, ax_d}) - $signed({1'b0, bx_d});
  assign dty       = $signed({1'b0, y_q})  - $signed({1'b0, by_d});
  assign prod0     = (2*W+2)'(dtx) * (2*W+2)'(day);
  assign prod1     = (2*W+2)'(dax) * (2*W+2)'(dty);
  assign s_edge    = (2*W+3)'(prod0) - (2*W+3)'(prod1);
  assign edge_pass = ~s_edge[2*W+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vx_q     <= '0;
      vy_q     <= '0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      ymin_q   <= '0;
      ymax_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      inside_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (bus.start) begin
          vx_q    <= {bus.p3X, bus.p2X, bus.p1X};
          vy_q    <= {bus.p3Y, bus.p2Y, bus.p1Y};
          cnt_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_BBOX;
        end
        S_BBOX: begin
          xmin_q  <= min3(vx_q[0], vx_q[1], vx_q[2]);
          xmax_q  <= max3(vx_q[0], vx_q[1], vx_q[2]);
          ymin_q  <= min3(vy_q[0], vy_q[1], vy_q[2]);
          ymax_q  <= max3(vy_q[0], vy_q[1], vy_q[2]);
          x_q     <= min3(vx_q[0], vx_q[1], vx_q[2]);
          y_q     <= min3(vy_q[0], vy_q[1], vy_q[2]);
          k_q     <= '0;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (!edge_pass) begin
            inside_q <= 1'b0;
            if (EMIT_ALL) begin
              valid_q <= 1'b1;
              state_q <= S_EMIT;
            end else begin
              state_q <= S_NEXT;
            end
          end else if (k_q != 2'd2) begin
            k_q <= k_q + 2'd1;
          end else begin
            inside_q <= 1'b1;
            cnt_q    <= cnt_q + 1'b1;
            valid_q  <= 1'b1;
            state_q  <= S_EMIT;
          end
        end
        S_EMIT: if (bus.pix_ready) begin
          valid_q <= 1'b0;
          state_q <= S_NEXT;
        end
        // Compare against the box edge before incrementing so 2^W-1 never wraps.
        S_NEXT: begin
          k_q <= '0;
          if (x_q == xmax_q && y_q == ymax_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (x_q == xmax_q) begin
            x_q     <= xmin_q;
            y_q     <= y_q + 1'b1;
            state_q <= S_EVAL;
          end else begin
            x_q     <= x_q + 1'b1;
            state_q <= S_EVAL;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_in    = inside_q;
  assign bus.pix_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.in_count  = cnt_q;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Bench for tri_raster_ctrl: two instances (emit-all and inside-only) run the
// same scans and are scored against a plain-arithmetic triangle model.
module tb_tri_raster_ctrl;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_raster_ctrl_if #(.W(W)) ifa ();
  tri_raster_ctrl_if #(.W(W)) ifi ();

  tri_raster_ctrl #(.W(W), .EMIT_ALL(1'b1)) u_all (.clk(clk), .rst(rst), .bus(ifa.slave));
  tri_raster_ctrl #(.W(W), .EMIT_ALL(1'b0)) u_ins (.clk(clk), .rst(rst), .bus(ifi.slave));

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         in;
  } beat_t;

  int    ncmp = 0;
  int    nfail = 0;
  beat_t exp_q[$];
  beat_t got_a[$];
  beat_t got_i[$];
  int    exp_cnt;
  int    done_a = 0, done_i = 0;
  int    base_a, base_i, dbase_a, dbase_i;
  bit    rnd_ready = 1'b0;
  bit    rdy_hold  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sink readiness changes just after each rising edge.
  initial begin
    ifa.pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifa.pix_ready = rdy_hold ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end
  initial begin
    ifi.pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      ifi.pix_ready = rdy_hold ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  beat_t hold_a, hold_i;
  bit    hold_a_v = 1'b0, hold_i_v = 1'b0;
  always @(negedge clk) begin
    if (ifa.pix_valid && ifa.pix_ready) got_a.push_back({ifa.pix_x, ifa.pix_y, ifa.pix_in});
    if (hold_a_v && ifa.pix_valid) check("stable_all", {ifa.pix_x, ifa.pix_y, ifa.pix_in}, hold_a);
    hold_a_v <= ifa.pix_valid && !ifa.pix_ready;
    hold_a   <= {ifa.pix_x, ifa.pix_y, ifa.pix_in};
    if (ifa.done) done_a <= done_a + 1;
  end
  always @(negedge clk) begin
    if (ifi.pix_valid && ifi.pix_ready) got_i.push_back({ifi.pix_x, ifi.pix_y, ifi.pix_in});
    if (hold_i_v && ifi.pix_valid) check("stable_ins", {ifi.pix_x, ifi.pix_y, ifi.pix_in}, hold_i);
    hold_i_v <= ifi.pix_valid && !ifi.pix_ready;
    hold_i   <= {ifi.pix_x, ifi.pix_y, ifi.pix_in};
    if (ifi.done) done_i <= done_i + 1;
  end

  function automatic longint side(longint ax, ay, bx, by, tx, ty);
    return (tx - bx) * (ay - by) - (ax - bx) * (ty - by);
  endfunction

  // Reference: every box pixel in row-major order, inside iff all three sides >= 0.
  task automatic build_model(input int x1, y1, x2, y2, x3, y3);
    int xl, xh, yl, yh;
    bit in;
    exp_q.delete();
    exp_cnt = 0;
    xl = (x1 < x2) ? x1 : x2; xl = (x3 < xl) ? x3 : xl;
    xh = (x1 > x2) ? x1 : x2; xh = (x3 > xh) ? x3 : xh;
    yl = (y1 < y2) ? y1 : y2; yl = (y3 < yl) ? y3 : yl;
    yh = (y1 > y2) ? y1 : y2; yh = (y3 > yh) ? y3 : yh;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        in = side(x1, y1, x2, y2, x, y) >= 0 && side(x2, y2, x3, y3, x, y) >= 0 &&
             side(x3, y3, x1, y1, x, y) >= 0;
        exp_q.push_back({W'(x), W'(y), in});
        if (in) exp_cnt++;
      end
  endtask

  task automatic drive_start(input int x1, y1, x2, y2, x3, y3);
    @(negedge clk);
    ifa.p1X = W'(x1); ifa.p1Y = W'(y1); ifa.p2X = W'(x2);
    ifa.p2Y = W'(y2); ifa.p3X = W'(x3); ifa.p3Y = W'(y3);
    ifi.p1X = W'(x1); ifi.p1Y = W'(y1); ifi.p2X = W'(x2);
    ifi.p2Y = W'(y2); ifi.p3X = W'(x3); ifi.p3Y = W'(y3);
    ifa.start = 1'b1; ifi.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifi.start = 1'b0;
  endtask

  task automatic begin_scan(input int x1, y1, x2, y2, x3, y3, input bit rnd);
    build_model(x1, y1, x2, y2, x3, y3);
    base_a = got_a.size(); base_i = got_i.size();
    dbase_a = done_a; dbase_i = done_i;
    rnd_ready = rnd;
    drive_start(x1, y1, x2, y2, x3, y3);
  endtask

  task automatic finish_scan(input string tag);
    int cyc = 0;
    int j = 0;
    while ((done_a == dbase_a || done_i == dbase_i) && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    check({tag, "_timeout"}, 64'(cyc < 20000), 64'd1);
    @(negedge clk); @(negedge clk);
    check({tag, "_nbeats_all"}, 64'(got_a.size() - base_a), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base_a + i < got_a.size(); i++)
      check({tag, "_beat_all"}, 64'(got_a[base_a + i]), 64'(exp_q[i]));
    check({tag, "_nbeats_ins"}, 64'(got_i.size() - base_i), 64'(exp_cnt));
    foreach (exp_q[i]) if (exp_q[i].in) begin
      if (base_i + j < got_i.size())
        check({tag, "_beat_ins"}, 64'(got_i[base_i + j]), 64'(exp_q[i]));
      j++;
    end
    check({tag, "_done_all"}, 64'(done_a - dbase_a), 64'd1);
    check({tag, "_done_ins"}, 64'(done_i - dbase_i), 64'd1);
    check({tag, "_cnt_all"}, 64'(ifa.in_count), 64'(exp_cnt));
    check({tag, "_cnt_ins"}, 64'(ifi.in_count), 64'(exp_cnt));
    check({tag, "_busy"}, 64'({ifa.busy, ifi.busy}), 64'd0);
  endtask

  function automatic int find_in(input int x, y);
    for (int i = base_a; i < got_a.size(); i++)
      if (got_a[i].x == W'(x) && got_a[i].y == W'(y)) return int'(got_a[i].in);
    return -1;
  endfunction

  initial begin
    int cyc;
    ifa.start = 1'b0; ifi.start = 1'b0;
    ifa.p1X = '0; ifa.p1Y = '0; ifa.p2X = '0; ifa.p2Y = '0; ifa.p3X = '0; ifa.p3Y = '0;
    ifi.p1X = '0; ifi.p1Y = '0; ifi.p2X = '0; ifi.p2Y = '0; ifi.p3X = '0; ifi.p3Y = '0;

    #12;
    check("reset_outs", 64'({ifa.busy, ifa.pix_valid, ifa.pix_in, ifa.done,
                            ifa.pix_x, ifa.pix_y, ifa.in_count}), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Abort mid-scan while a beat is waiting on the sink.
    rdy_hold = 1'b1;
    begin_scan(0, 0, 4, 0, 2, 4, 1'b0);
    cyc = 0;
    while (!ifa.pix_valid && cyc < 50) begin @(negedge clk); cyc++; end
    check("abort_reach_emit", 64'(ifa.pix_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_outs_all", 64'({ifa.busy, ifa.pix_valid, ifa.pix_in, ifa.done,
                                ifa.pix_x, ifa.pix_y, ifa.in_count}), 64'd0);
    check("abort_outs_ins", 64'({ifi.busy, ifi.pix_valid, ifi.pix_in, ifi.done,
                                ifi.pix_x, ifi.pix_y, ifi.in_count}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; rdy_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done_a - dbase_a + done_i - dbase_i), 64'd0);

    begin_scan(0, 0, 4, 0, 2, 4, 1'b0);
    finish_scan("tri_small");
    check("tri_small_cnt13", 64'(ifa.in_count), 64'd13);

    begin_scan(20, 20, 40, 20, 30, 40, 1'b1);
    finish_scan("tri_mid_rnd");
    check("tri_mid_441", 64'(got_a.size() - base_a), 64'd441);
    check("pix_25_25", 64'(find_in(25, 25)), 64'd1);
    check("pix_20_22", 64'(find_in(20, 22)), 64'd0);

    begin_scan(0, 0, 2, 4, 4, 0, 1'b0);
    finish_scan("tri_cw");
    check("tri_cw_cnt0", 64'(ifa.in_count), 64'd0);

    begin_scan(4095, 4095, 4095, 4095, 4095, 4095, 1'b1);
    finish_scan("corner_pt");
    check("corner_cnt1", 64'(ifa.in_count), 64'd1);

    // Second start mid-scan with different vertices must not disturb the scan.
    begin_scan(20, 20, 40, 20, 30, 40, 1'b1);
    repeat (40) @(negedge clk);
    drive_start(1, 1, 6, 1, 3, 6);
    finish_scan("start_busy");

    for (int t = 0; t < 4; t++) begin
      int v[6];
      foreach (v[i]) v[i] = (t == 3) ? 4095 - $urandom_range(0, 9) : $urandom_range(0, 14);
      begin_scan(v[0], v[1], v[2], v[3], v[4], v[5], 1'b1);
      finish_scan($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/tri_raster_ctrl.md
Name: tri_raster_ctrl

Overview:
- Sequential scan controller for the triangle point-inclusion test.
- Latches three vertices on `start` and computes their bounding box.
- Walks every pixel of the box row-major, time-sharing one edge-sign evaluator across the three edges (one edge per clock, early exit on a failing edge).
- Streams pixel results out over a valid/ready handshake; sits between the vertex source and the pixel/framebuffer writer.

Parameters:
- W, 12, coordinate width (unsigned vertex and pixel coordinates).
- EMIT_ALL, 1: 1 = emit every box pixel with its `pix_in` flag; 0 = emit only inside pixels.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a scan; sampled only in IDLE
- p1X, p1Y, p2X, p2Y, p3X, p3Y  in  W each  vertex coordinates; sampled on accepted `start`
- busy  out  1  high from the cycle after accepted `start` until DONE completes
- pix_x, pix_y  out  W each  current emitted pixel
- pix_in  out  1  1 = pixel inside or on an edge
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  sink accepts the pixel
- done  out  1  one-cycle pulse at end of scan
- in_count  out  2W+1  number of inside pixels in the last/current scan

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - busy, pix_valid, pix_in, done = 0.
  - pix_x, pix_y, in_count = 0.
  - Vertex registers = 0.
  - Reset mid-scan aborts immediately; no done pulse.
- Edge function, evaluated for edge k with (A,B) = (p1,p2), (p2,p3), (p3,p1) for k = 0, 1, 2 and test point T:
  - Operands zero-extended to W+1-bit signed.
  - S = (Tx−Bx)(Ay−By) − (Ax−Bx)(Ty−By).
  - Products are 2W+2 bits signed; S is 2W+3 bits signed, so there is no overflow.
  - Edge passes iff S ≥ 0.
  - Pixel is inside iff all three edges pass; boundary is inclusive.
  - No orientation correction: a clockwise triangle yields zero inside pixels.
- States:
  - IDLE:
    - When `start` = 1, latch vertices, clear in_count, go to BBOX.
    - `start` is ignored in every other state.
  - BBOX (1 cycle):
    - Register xmin/xmax/ymin/ymax as the min/max of the three vertices.
    - Set x = xmin, y = ymin, k = 0; go to EVAL.
  - EVAL (1 cycle per edge):
    - Evaluate edge k at (x, y).
    - If the edge fails: inside = 0 and go to EMIT if EMIT_ALL = 1, else go to NEXT.
    - If it passes and k < 2: k++, stay in EVAL.
    - If it passes and k = 2: inside = 1, in_count++, go to EMIT.
  - EMIT:
    - pix_valid = 1 with stable pix_x = x, pix_y = y, pix_in = inside.
    - Hold until pix_ready = 1 in the same cycle (handshake).
    - On handshake, pix_valid drops next cycle and go to NEXT.
    - pix_ready while not valid is ignored.
  - NEXT (1 cycle), k = 0:
    - If x = xmax and y = ymax: go to DONE.
    - Else if x = xmax: x = xmin, y++, go to EVAL.
    - Else: x++, go to EVAL.
  - DONE: done = 1 for one cycle; busy = 0 next cycle; go to IDLE.
- Latency, counted from the clock edge sampling `start` (edge 0), with ready always high:
  - First pix_valid is at cycle 3 (edge 0 fails) to cycle 5 (inside).
  - Per-pixel cost is 1 NEXT + 1–3 EVAL + 1 EMIT.
- Boundary cases:
  - A degenerate box (xmin = xmax and/or ymin = ymax) scans its single row, column or pixel.
  - Coordinates at 2^W−1 must not wrap: the NEXT comparisons happen before any increment.
- in_count:
  - Holds after DONE until the next accepted start.
  - Max (2^W)^2 fits in 2W+1 bits.

Test Plan:
- Reset mid-scan: pulse rst during EMIT → all outputs 0 asynchronously, state IDLE, no done; a following start scans normally.
- Triangle (0,0),(4,0),(2,4), EMIT_ALL = 1, ready = 1 → 25 pixels in row-major order from (0,0) to (4,4).
  - Inside rows are y0: x0–4; y1: x1–3; y2: x1–3; y3: x2; y4: x2.
  - in_count = 13; one done pulse after (4,4).
- Same triangle, EMIT_ALL = 0 → exactly 13 beats, all pix_in = 1, same coordinates.
- Triangle (20,20),(40,20),(30,40), EMIT_ALL = 1, with pix_ready toggling randomly:
  - Pixel (25,25) has pix_in = 1.
  - Pixel (20,22) has pix_in = 0.
  - pix_x/pix_y/pix_in stay stable while valid and not ready; no beat is lost or duplicated; 441 beats in total.
- Clockwise triangle (0,0),(2,4),(4,0) → 25 beats, all pix_in = 0, in_count = 0.
- Degenerate/edge cases:
  - All vertices at (4095,4095) → one beat, pix_in = 1, in_count = 1, done, no wrap.
  - `start` asserted while busy → ignored, scan unaffected.
